// File: rtl/ssram_stream_pkg.sv
// Shared types and constants for the SSRAM stream reader.
package ssram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int unsigned BUFFER_DEPTH = 3;

    // Counters must hold a full word count, which may equal nrOfEntries.
    function automatic int unsigned cnt_width(input int unsigned entries);
        return $clog2(entries) + 1;
    endfunction

endpackage

// File: rtl/ssram_stream_buffer.sv
// Three-entry synchronous FIFO that decouples SSRAM read data from the stream sink.
module ssram_stream_buffer
    import ssram_stream_pkg::*;
#(
    parameter int unsigned bitwidth = 32
) (
    input  logic                clock,
    input  logic                nReset,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [bitwidth-1:0] pushData,
    output logic [1:0]          count,
    output logic [bitwidth-1:0] headData
);

    logic [bitwidth-1:0] mem_q [BUFFER_DEPTH];
    logic [1:0]          rdPtr_q, rdPtr_d;
    logic [1:0]          wrPtr_q, wrPtr_d;
    logic [1:0]          count_q, count_d;
    logic                doPop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(BUFFER_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign doPop    = pop && (count_q != 2'd0);
    assign count    = count_q;
    assign headData = mem_q[rdPtr_q];

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = wrPtr_q;
            count_d = 2'd0;
        end else begin
            if (push) wrPtr_d = next_ptr(wrPtr_q);
            if (doPop) rdPtr_d = next_ptr(rdPtr_q);
            count_d = count_q + 2'(push) - 2'(doPop);
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < BUFFER_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            if (push && !flush) mem_q[wrPtr_q] <= pushData;
        end
    end

endmodule

// File: rtl/ssram_stream_reader.sv
// Streams a range of SSRAM words out as valid/ready data, hiding the RAM's
// one-cycle read latency behind a small buffer.
module ssram_stream_reader
    import ssram_stream_pkg::*;
#(
    parameter  int unsigned bitwidth    = 32,
    parameter  int unsigned nrOfEntries = 512,
    localparam int unsigned AW          = $clog2(nrOfEntries),
    localparam int unsigned CW          = cnt_width(nrOfEntries)
) (
    input  logic                clock,
    input  logic                nReset,
    input  logic                start,
    input  logic [AW-1:0]       startAddress,
    input  logic [AW:0]         wordCount,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       ramAddress,
    input  logic [bitwidth-1:0] ramDataOut,
    output logic [bitwidth-1:0] streamData,
    output logic                streamValid,
    input  logic                streamReady
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(nrOfEntries - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] toIssue_q, toIssue_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic          inFlight_q, inFlight_d;

    logic [1:0]    bufCount;
    logic [2:0]    occupancy;
    logic          issue, pop, push, flush;

    assign occupancy   = {1'b0, bufCount} + {2'b0, inFlight_q};
    assign issue       = (state_q == RUN) && !abort && (toIssue_q != '0)
                         && (occupancy < 3'(BUFFER_DEPTH));
    assign streamValid = (bufCount != 2'd0);
    assign pop         = streamValid && streamReady;
    assign flush       = (state_q == RUN) && abort;
    // A read still in flight when aborting is dropped rather than captured.
    assign push        = inFlight_q && !flush;

    assign ramAddress  = addr_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == FINISH);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        toIssue_d   = toIssue_q;
        remaining_d = remaining_q;
        inFlight_d  = issue;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (wordCount == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d     = RUN;
                        addr_d      = startAddress;
                        toIssue_d   = wordCount;
                        remaining_d = wordCount;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    toIssue_d = toIssue_q - 1'b1;
                end
                if (pop) remaining_d = remaining_q - 1'b1;
                if (abort || (pop && remaining_q == CW'(1))) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            toIssue_q   <= '0;
            remaining_q <= '0;
            inFlight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            toIssue_q   <= toIssue_d;
            remaining_q <= remaining_d;
            inFlight_q  <= inFlight_d;
        end
    end

    ssram_stream_buffer #(
        .bitwidth(bitwidth)
    ) u_buffer (
        .clock    (clock),
        .nReset   (nReset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .pushData (ramDataOut),
        .count    (bufCount),
        .headData (streamData)
    );

endmodule
